// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB-lite master arbiter.
// Supplies fallback bus widths when AHB_ADDR_WIDTH / AHB_DATA_WIDTH are not defined by the build.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   localparam int TIMEOUT_DEFAULT = 64;

   // Width of an index into n requesters; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Combinational requester picker: first active request at or after start_ptr_i, wrapping at N-1 -> 0.
// With start_ptr_i tied to zero this degenerates to fixed lowest-index priority.
module ahb_arb_picker
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   localparam int IW = idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IW-1:0]          start_ptr_i,
   output logic [NUM_MASTERS-1:0] gnt_o,
   output logic [IW-1:0]          idx_o,
   output logic                   valid_o
);

   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      cand     = 0;
      cand_idx = '0;
      gnt_o    = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      for (int off = 0; off < NUM_MASTERS; off++) begin
         cand = int'(start_ptr_i) + off;
         if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
         cand_idx = IW'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o         = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-lite master port between NUM_MASTERS requesters: IDLE -> REQ -> XFER -> DONE -> IDLE.
// Define AHB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_master_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
   parameter int AW          = `AHB_ADDR_WIDTH,
   parameter int DW          = `AHB_DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MASTERS-1:0]    m_req,
   input  logic [NUM_MASTERS*AW-1:0] m_addr,
   input  logic [NUM_MASTERS-1:0]    m_write,
   input  logic [NUM_MASTERS*DW-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]    m_grant,
   output logic [NUM_MASTERS-1:0]    m_done,
   output logic                      m_err,
   output logic [DW-1:0]             m_rdata,
   output logic [AW-1:0]             haddr,
   output logic                      haddr_ctrl,
   output logic                      hwrite,
   output logic [DW-1:0]             hwdata,
   output logic                      hbusreq,
   input  logic                      hgrant,
   input  logic [DW-1:0]             hdata_s2m,
   input  logic                      hresp_s2m,
   input  logic                      hready_s2m
);

   localparam int IW = idx_w(NUM_MASTERS);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   arb_state_t             state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [NUM_MASTERS-1:0] done_q, done_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [DW-1:0]          wdata_q, wdata_d;
   logic [DW-1:0]          rdata_q, rdata_d;
   logic                   write_q, write_d;
   logic                   err_q, err_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IW-1:0]          pick_idx;
   logic                   pick_valid;
   logic [IW-1:0]          start_ptr;

   logic [AW-1:0] addr_arr  [NUM_MASTERS];
   logic [DW-1:0] wdata_arr [NUM_MASTERS];

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign addr_arr[g]  = m_addr[g*AW +: AW];
      assign wdata_arr[g] = m_wdata[g*DW +: DW];
   end

`ifdef AHB_ARB_RR_EN
   logic [IW-1:0] rr_q, rr_d;

   // Next search starts just past the master that completed last.
   always_comb begin
      rr_d = rr_q;
      if (state_q == DONE)
         rr_d = (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + IW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) rr_q <= '0;
      else     rr_q <= rr_d;
   end

   assign start_ptr = rr_q;
`else
   assign start_ptr = '0;
`endif

   ahb_arb_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req_i       (m_req),
      .start_ptr_i (start_ptr),
      .gnt_o       (pick_gnt),
      .idx_o       (pick_idx),
      .valid_o     (pick_valid)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      cnt_d   = cnt_q;
      done_d  = '0;
      err_d   = 1'b0;
      rdata_d = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               grant_d = pick_gnt;
               addr_d  = addr_arr[pick_idx];
               wdata_d = wdata_arr[pick_idx];
               write_d = m_write[pick_idx];
               state_d = REQ;
            end
         end
         REQ: begin
            if (hgrant) begin
               cnt_d   = '0;
               state_d = XFER;
            end else if (!m_req[owner_q]) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         XFER: begin
            cnt_d = cnt_q + CW'(1);
            // A completing beat beats the timeout when both land in the same cycle.
            if (hready_s2m) begin
               done_d  = grant_q;
               err_d   = hresp_s2m;
               rdata_d = write_q ? '0 : hdata_s2m;
               grant_d = '0;
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               done_d  = grant_q;
               err_d   = 1'b1;
               grant_d = '0;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         grant_q <= '0;
         done_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         write_q <= write_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hbusreq    = (state_q == REQ) || (state_q == XFER);
   assign haddr_ctrl = hbusreq;
   assign haddr      = addr_q;
   assign hwrite     = write_q;
   assign hwdata     = wdata_q;
   assign m_grant    = grant_q;
   assign m_done     = done_q;
   assign m_err      = err_q;
   assign m_rdata    = rdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter (2 masters, short timeout) with a completion scoreboard.
module tb_ahb_master_arbiter;

   localparam int N  = 2;
   localparam int T  = 8;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_req;
   logic [N*AW-1:0] m_addr;
   logic [N-1:0]    m_write;
   logic [N*DW-1:0] m_wdata;
   logic [N-1:0]    m_grant;
   logic [N-1:0]    m_done;
   logic            m_err;
   logic [DW-1:0]   m_rdata;
   logic [AW-1:0]   haddr;
   logic            haddr_ctrl;
   logic            hwrite;
   logic [DW-1:0]   hwdata;
   logic            hbusreq;
   logic            hgrant;
   logic [DW-1:0]   hdata_s2m;
   logic            hresp_s2m;
   logic            hready_s2m;

   typedef struct {
      logic [N-1:0]  done;
      logic          err;
      logic [DW-1:0] rdata;
   } sb_t;

   sb_t sb[$];
   int  total  = 0;
   int  passed = 0;

   always #5 clk = ~clk;

   ahb_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYC(T), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .m_req      (m_req),
      .m_addr     (m_addr),
      .m_write    (m_write),
      .m_wdata    (m_wdata),
      .m_grant    (m_grant),
      .m_done     (m_done),
      .m_err      (m_err),
      .m_rdata    (m_rdata),
      .haddr      (haddr),
      .haddr_ctrl (haddr_ctrl),
      .hwrite     (hwrite),
      .hwdata     (hwdata),
      .hbusreq    (hbusreq),
      .hgrant     (hgrant),
      .hdata_s2m  (hdata_s2m),
      .hresp_s2m  (hresp_s2m),
      .hready_s2m (hready_s2m)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Waits (bounded) for the completion pulse, then pops and checks the scoreboard entry.
   task automatic wait_done(input string tag, input int budget, output int n);
      sb_t e;
      n = 0;
      while (m_done === '0 && n < budget) begin
         tick();
         n++;
      end
      if (m_done === '0) begin
         chk({tag, "_done_seen"}, 64'd0, 64'd1);
      end else if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_done"}, m_done, e.done);
         chk({tag, "_err"}, m_err, e.err);
         chk({tag, "_rdata"}, m_rdata, e.rdata);
         chk({tag, "_busreq_off"}, hbusreq, 0);
         chk({tag, "_grant_off"}, m_grant, 0);
      end
   endtask

   // Grants the bus to the pending owner and completes in the first XFER cycle.
   task automatic bus_respond(input string tag, input logic [N-1:0] exp_g, input logic resp,
                              input logic [DW-1:0] data, input logic wr);
      sb_t e;
      int  n = 0;
      int  dn;
      while (hbusreq !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_busreq"}, hbusreq, 1);
      chk({tag, "_grant"}, m_grant, exp_g);
      hgrant = 1'b1;
      tick();
      hgrant     = 1'b0;
      hready_s2m = 1'b1;
      hresp_s2m  = resp;
      hdata_s2m  = data;
      e.done  = exp_g;
      e.err   = resp;
      e.rdata = wr ? '0 : data;
      sb.push_back(e);
      tick();
      hready_s2m = 1'b0;
      hresp_s2m  = 1'b0;
      hdata_s2m  = '0;
      wait_done(tag, 5, dn);
   endtask

   initial begin
      sb_t            e;
      int             dn;
      logic [N-1:0]   exp_seq [4];

      rst        = 1'b1;
      m_req      = '0;
      m_addr     = '0;
      m_write    = '0;
      m_wdata    = '0;
      hgrant     = 1'b0;
      hdata_s2m  = '0;
      hresp_s2m  = 1'b0;
      hready_s2m = 1'b0;
      repeat (3) tick();
      chk("rst_grant", m_grant, 0);
      chk("rst_done", m_done, 0);
      chk("rst_busreq", hbusreq, 0);
      chk("rst_actrl", haddr_ctrl, 0);
      chk("rst_haddr", haddr, 0);
      chk("rst_err", m_err, 0);
      chk("rst_rdata", m_rdata, 0);
      rst = 1'b0;
      tick();

      // Single read, hgrant one cycle late, requester changes address after grant.
      m_req          = 2'b01;
      m_addr[0+:AW]  = 32'h0000_1000;
      tick();
      chk("rd_grant", m_grant, 2'b01);
      chk("rd_busreq", hbusreq, 1);
      chk("rd_actrl", haddr_ctrl, 1);
      chk("rd_haddr", haddr, 32'h1000);
      chk("rd_hwrite", hwrite, 0);
      m_addr[0+:AW] = 32'h0000_2222;
      tick();
      chk("rd_haddr_held", haddr, 32'h1000);
      bus_respond("rd", 2'b01, 1'b0, 32'hDEAD_BEEF, 1'b0);
      m_req = '0;
      tick();
      chk("rd_done_pulse", m_done, 0);

      // Error response on a write from master 1.
      m_req              = 2'b10;
      m_write            = 2'b10;
      m_addr[AW+:AW]     = 32'h0000_3000;
      m_wdata[DW+:DW]    = 32'hCAFE_F00D;
      tick();
      chk("wr_hwrite", hwrite, 1);
      chk("wr_hwdata", hwdata, 32'hCAFE_F00D);
      chk("wr_haddr", haddr, 32'h3000);
      bus_respond("wr_err", 2'b10, 1'b1, 32'h1234_5678, 1'b1);
      m_req   = '0;
      m_write = '0;
      tick();

      // Contention with both requests held; one idle bubble between transactions.
`ifdef AHB_ARB_RR_EN
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      m_addr[0+:AW]  = 32'h0000_4000;
      m_addr[AW+:AW] = 32'h0000_5000;
      m_req          = 2'b11;
      for (int i = 0; i < 4; i++) begin
         bus_respond($sformatf("cont%0d", i), exp_seq[i], 1'b0, 32'h1000_0000 + DW'(i), 1'b0);
         if (i == 3) m_req = '0;
         tick();
         chk($sformatf("cont%0d_bubble", i), hbusreq, 0);
      end

      // Timeout: granted, hready never arrives.
      m_req         = 2'b01;
      m_addr[0+:AW] = 32'h0000_6000;
      tick();
      hgrant = 1'b1;
      tick();
      hgrant    = 1'b0;
      hdata_s2m = 32'hBAD0_BAD0;
      e.done = 2'b01; e.err = 1'b1; e.rdata = '0;
      sb.push_back(e);
      wait_done("tmo", 3 * T, dn);
      chk("tmo_cycles", dn, T);
      m_req     = '0;
      hdata_s2m = '0;
      tick();

      // hready in the last timeout cycle: completion wins, no error.
      m_req = 2'b01;
      tick();
      hgrant = 1'b1;
      tick();
      hgrant = 1'b0;
      repeat (T - 1) tick();
      chk("tmo_edge_busreq", hbusreq, 1);
      hready_s2m = 1'b1;
      hdata_s2m  = 32'hA5A5_5A5A;
      e.done = 2'b01; e.err = 1'b0; e.rdata = 32'hA5A5_5A5A;
      sb.push_back(e);
      tick();
      hready_s2m = 1'b0;
      hdata_s2m  = '0;
      wait_done("tmo_edge", 5, dn);
      m_req = '0;
      tick();

      // Abort in REQ: master 0 withdraws, pending master 1 then served.
      m_req = 2'b01;
      tick();
      chk("abort_g0", m_grant, 2'b01);
      m_req = 2'b11;
      tick();
      chk("abort_hold", m_grant, 2'b01);
      m_req = 2'b10;
      tick();
      chk("abort_grant", m_grant, 0);
      chk("abort_busreq", hbusreq, 0);
      chk("abort_nodone", m_done, 0);
      bus_respond("abort_m1", 2'b10, 1'b0, 32'h0BAD_F00D, 1'b0);
      m_req = '0;
      tick();

      // Reset during XFER, then a fresh request.
      m_req         = 2'b01;
      m_addr[0+:AW] = 32'h0000_7000;
      tick();
      hgrant = 1'b1;
      tick();
      hgrant = 1'b0;
      chk("rx_busreq", hbusreq, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rx_grant", m_grant, 0);
      chk("rx_busreq_off", hbusreq, 0);
      chk("rx_done", m_done, 0);
      chk("rx_haddr", haddr, 0);
      bus_respond("rx_new", 2'b01, 1'b0, 32'h7777_0001, 1'b0);
      m_req = '0;
      tick();

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
